// File: rtl/audio_adc_rx_if.sv
// Avalon-ST style stereo-pair stream between the ADC receiver and its sink.
// Signals:
//   src_data  : {left, right} pair, left in the upper half
//   src_valid : head entry present
//   src_ready : sink accepts the head entry
interface audio_adc_rx_if #(
  parameter int unsigned DATA_W = 24
);
  logic [2*DATA_W-1:0] src_data;
  logic                src_valid;
  logic                src_ready;

  modport master (output src_data, output src_valid, input src_ready);
  modport slave  (input src_data, input src_valid, output src_ready);
endinterface

// File: rtl/audio_adc_rx.sv
// I2S record-path receiver: deserialises the codec ADC stream into stereo
// pairs, buffers them in a show-ahead FIFO and offers them on a stream source.
// Ports:
//   clk, reset_n           : system clock, async active-low reset
//   bclk, adclrck, adcdat  : codec pins (asynchronous, codec is master)
//   enable                 : receiver enable
//   src                    : stream source (src_data/src_valid/src_ready)
//   overflow, frame_err    : sticky error flags
//   clr_flags              : pulse clearing both flags (a coincident set wins)
module audio_adc_rx #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bclk,
  input  logic                  adclrck,
  input  logic                  adcdat,
  input  logic                  enable,
  audio_adc_rx_if.master        src,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  clr_flags
);

  localparam int unsigned PAIR_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_SHIFT,
    S_WAIT
  } state_t;

  // Pin synchronisers: [0],[1] synchroniser stages, [2] edge register
  logic [2:0] bclk_sr;
  logic [2:0] lr_sr;
  logic [1:0] dat_sr;
  logic       bclk_rise;
  logic       lr_fall;
  logic       lr_rise;
  logic       dat_bit;

  // Strobes and the data bit are all registered from stage 2 so they stay aligned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sr   <= '0;
      lr_sr     <= '0;
      dat_sr    <= '0;
      bclk_rise <= 1'b0;
      lr_fall   <= 1'b0;
      lr_rise   <= 1'b0;
      dat_bit   <= 1'b0;
    end else begin
      bclk_sr   <= {bclk_sr[1:0], bclk};
      lr_sr     <= {lr_sr[1:0], adclrck};
      dat_sr    <= {dat_sr[0], adcdat};
      bclk_rise <= bclk_sr[1] & ~bclk_sr[2];
      lr_fall   <= lr_sr[2] & ~lr_sr[1];
      lr_rise   <= lr_sr[1] & ~lr_sr[2];
      dat_bit   <= dat_sr[1];
    end
  end

  // Deserialiser state
  state_t              state, state_n;
  logic                ch, ch_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DATA_W-1:0]   sh, sh_n;
  logic [DATA_W-1:0]   left_q, left_n;
  logic                push_c;
  logic                ferr_set_c;
  logic [PAIR_W-1:0]   pair_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ch     <= 1'b0;
      cnt    <= '0;
      sh     <= '0;
      left_q <= '0;
    end else begin
      state  <= state_n;
      ch     <= ch_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      left_q <= left_n;
    end
  end

  // Next-state: slot framing, bit capture, short-slot detection
  always_comb begin
    state_n    = state;
    ch_n       = ch;
    cnt_n      = cnt;
    sh_n       = sh;
    left_n     = left_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (lr_fall) begin
            ch_n    = 1'b0;
            state_n = S_SKIP;
          end
        end
        S_SKIP: begin
          // I2S one-bit delay slot: this bit belongs to nobody
          if (bclk_rise) begin
            cnt_n   = '0;
            state_n = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (lr_fall) begin
            ferr_set_c = 1'b1;
            ch_n       = 1'b0;
            state_n    = S_SKIP;
          end else if (lr_rise) begin
            ferr_set_c = 1'b1;
            state_n    = S_IDLE;
          end else if (bclk_rise) begin
            sh_n  = {sh[DATA_W-2:0], dat_bit};
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state_n = S_WAIT;
              if (!ch) left_n = sh_n;
              else     push_c = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (lr_rise && !ch) begin
            ch_n    = 1'b1;
            state_n = S_SKIP;
          end else if (lr_fall && ch) begin
            ch_n    = 1'b0;
            state_n = S_SKIP;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign pair_c = {left_q, sh_n};

  // Show-ahead FIFO
  logic [PAIR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_n;
  logic              valid_q;
  logic              pop_c;
  logic              full_c;
  logic              do_push_c;
  logic              drop_c;

  // A pop frees the slot in the same cycle, so a push into a full FIFO survives it
  always_comb begin
    pop_c     = valid_q & src.src_ready;
    full_c    = (level == LVL_W'(FIFO_DEPTH));
    do_push_c = push_c & (~full_c | pop_c);
    drop_c    = push_c & full_c & ~pop_c;
    level_n   = level + LVL_W'(do_push_c) - LVL_W'(pop_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= pair_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      level   <= level_n;
      valid_q <= (level_n != '0);
    end
  end

  assign src.src_data  = mem[rd_ptr];
  assign src.src_valid = valid_q;

  // Sticky flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop_c)         overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (ferr_set_c)     frame_err <= 1'b1;
      else if (clr_flags) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Scoreboard bench for audio_adc_rx: a codec model drives I2S frames, expected
// pairs are queued at stimulus time and a monitor checks every accepted beat.
module tb_audio_adc_rx;

  logic clk = 1'b0;
  logic reset_n;
  logic bclk;
  logic adclrck;
  logic adcdat;
  logic enable;
  logic overflow;
  logic frame_err;
  logic clr_flags;

  int total = 0;
  int bad   = 0;
  int lsb_cnt = 0;
  logic [47:0] exp_q [$];

  audio_adc_rx_if #(.DATA_W(24)) bus ();

  audio_adc_rx #(.DATA_W(24), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk      (bclk),
    .adclrck   (adclrck),
    .adcdat    (adcdat),
    .enable    (enable),
    .src       (bus),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_flags (clr_flags)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the head of the expectation queue
  always @(negedge clk) begin
    if (reset_n && bus.src_valid && bus.src_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h want none", bus.src_data);
      end else begin
        check("beat", bus.src_data, exp_q.pop_front());
      end
    end
  end

  // One codec slot: the first BCLK is the I2S delay bit, then MSB first
  task automatic slot(input logic lr, input logic [23:0] w, input int nbits);
    logic [23:0] s;
    s = w;
    for (int k = 0; k < nbits; k++) begin
      bclk = 1'b0;
      if (k == 0) adclrck = lr;
      if (k >= 1 && k <= 24) begin
        adcdat = s[23];
        s = {s[22:0], 1'b0};
      end else begin
        adcdat = 1'b0;
      end
      #160;
      bclk = 1'b1;
      if (lr && k == 24) lsb_cnt++;
      #160;
    end
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r);
    slot(1'b0, l, 32);
    slot(1'b1, r, 32);
  endtask

  task automatic expect_pair(input logic [23:0] l, input logic [23:0] r);
    exp_q.push_back({l, r});
  endtask

  // Pin edges 3 ns after a negedge, i.e. 7 ns before the next posedge
  task automatic align();
    @(negedge clk);
    #3;
  endtask

  // Frame with a one-cycle pulse covering exactly the push edge
  // (push lands on the 4th posedge after the right LSB pin rise)
  task automatic frame_pulse(input logic [23:0] l, input logic [23:0] r, input bit on_ready);
    int base;
    base = lsb_cnt;
    fork
      frame(l, r);
      begin
        wait (lsb_cnt != base);
        #55;
        if (on_ready) bus.src_ready = 1'b1;
        else          clr_flags = 1'b1;
        #20;
        bus.src_ready = 1'b0;
        clr_flags = 1'b0;
      end
    join
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 48'(exp_q.size()), 48'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic basic_test();
    int base;
    int n;
    base = lsb_cnt;
    n = 0;
    expect_pair(24'h123456, 24'hABCDEF);
    fork
      frame(24'h123456, 24'hABCDEF);
      begin
        wait (lsb_cnt != base);
        while (!bus.src_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("valid_latency_le5", 48'(n <= 5 && bus.src_valid), 48'd1);
      end
    join
    wait_drain("basic_drain");
    check("basic_frame_err", 48'(frame_err), 48'd0);
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    bclk = 1'b0;
    adclrck = 1'b1;
    adcdat = 1'b0;
    enable = 1'b1;
    clr_flags = 1'b0;
    bus.src_ready = 1'b1;
    #3;

    // Reset held while the codec pins toggle
    slot(1'b0, 24'hFFFFFF, 8);
    slot(1'b1, 24'hFFFFFF, 8);
    check("rst_valid", 48'(bus.src_valid), 48'd0);
    check("rst_data", bus.src_data, 48'd0);
    check("rst_overflow", 48'(overflow), 48'd0);
    check("rst_frame_err", 48'(frame_err), 48'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame
    align();
    basic_test();

    // Backpressure: five frames into a four-deep FIFO
    bus.src_ready = 1'b0;
    align();
    for (int n = 1; n <= 5; n++) begin
      if (n <= 4) expect_pair(24'(n), 24'(n + 'h100));
      frame(24'(n), 24'(n + 'h100));
    end
    repeat (4) @(negedge clk);
    check("bp_overflow", 48'(overflow), 48'd1);
    bus.src_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_valid_low", 48'(bus.src_valid), 48'd0);
    clear_flags();
    check("bp_overflow_cleared", 48'(overflow), 48'd0);

    // Short left slot, then a clean frame
    align();
    slot(1'b0, 24'hFFFF00, 16);
    slot(1'b1, 24'h0F0F0F, 32);
    check("short_frame_err", 48'(frame_err), 48'd1);
    expect_pair(24'hAAAAAA, 24'h555555);
    frame(24'hAAAAAA, 24'h555555);
    wait_drain("short_drain");
    clear_flags();
    check("frame_err_cleared", 48'(frame_err), 48'd0);

    // Enable dropped mid-left, restored mid-right
    align();
    fork
      frame(24'h111111, 24'h222222);
      begin
        #(320 * 10);
        enable = 1'b0;
        #(320 * 32);
        enable = 1'b1;
      end
    join
    expect_pair(24'h333333, 24'h444444);
    frame(24'h333333, 24'h444444);
    wait_drain("enable_drain");
    check("enable_frame_err", 48'(frame_err), 48'd0);

    // Full FIFO with a pop on the push cycle, then overflow coinciding with clr_flags
    bus.src_ready = 1'b0;
    align();
    for (int n = 1; n <= 4; n++) begin
      expect_pair(24'h500000 + 24'(n), 24'h600000 + 24'(n));
      frame(24'h500000 + 24'(n), 24'h600000 + 24'(n));
    end
    expect_pair(24'h500005, 24'h600005);
    frame_pulse(24'h500005, 24'h600005, 1'b1);
    repeat (4) @(negedge clk);
    check("full_pushpop_overflow", 48'(overflow), 48'd0);
    check("full_pushpop_valid", 48'(bus.src_valid), 48'd1);
    frame_pulse(24'h500006, 24'h600006, 1'b0);
    repeat (4) @(negedge clk);
    check("clr_vs_overflow", 48'(overflow), 48'd1);
    bus.src_ready = 1'b1;
    wait_drain("corner_drain");
    check("corner_valid_low", 48'(bus.src_valid), 48'd0);

    check("queue_empty", 48'(exp_q.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
